// File: rtl/note_seq_ctrl.sv
// note_seq_ctrl: owns the note RAM port, writing one note per beat while recording
// and reading notes back one per beat (optionally looping) during playback.
module note_seq_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tick,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [DATA_W-1:0] note_in,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] note_out,
  output logic              note_valid,
  output logic [ADDR_W:0]   rec_len,
  output logic              full,
  output logic [1:0]        state
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REC   = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] rp_q, rp_d, addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              full_q, full_d, pend_q, pend_d, wren_q, wren_d;
  logic              valid_q, valid_d, rd1_q, rd1_d, rd2_q, rd2_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, note_q, note_d;
  logic              abort;
  // The write pointer is rec_len itself: both advance together after each write.
  always_comb begin
    abort   = stop & state_q[1];
    state_d = state_q;
    rp_d    = rp_q;
    len_d   = len_q;
    full_d  = full_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    wren_d  = 1'b0;
    wdata_d = wdata_q;
    rd1_d   = 1'b0;
    rd2_d   = rd1_q & ~abort;
    valid_d = rd2_q & ~abort;
    note_d  = valid_d ? ram_q : note_q;
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (rec_start) begin
          state_d = S_REC;
          len_d   = '0;
          full_d  = 1'b0;
          pend_d  = 1'b0;
        end else if (play_start && len_q != '0) begin
          state_d = S_PLAY;
          rp_d    = '0;
        end
      end
      S_REC: begin
        if (wren_q) begin
          len_d = len_q + 1'b1;
          if (len_q == LAST) begin
            full_d  = 1'b1;
            state_d = S_IDLE;
          end else if (stop || pend_q) begin
            state_d = S_IDLE;
          end
        end else if (tick) begin
          wren_d  = 1'b1;
          addr_d  = len_q[ADDR_W-1:0];
          wdata_d = note_in;
          pend_d  = stop;
        end else if (stop) begin
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (tick && !rd1_q && !rd2_q) begin
          addr_d = rp_q;
          rd1_d  = 1'b1;
          if ({1'b0, rp_q} == len_q - 1'b1) begin
            rp_d    = '0;
            state_d = loop_en ? S_PLAY : S_DRAIN;
          end else begin
            rp_d = rp_q + 1'b1;
          end
        end
      end
      default: state_d = (stop || valid_q) ? S_IDLE : S_DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      rp_q    <= '0;
      len_q   <= '0;
      full_q  <= 1'b0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      wren_q  <= 1'b0;
      wdata_q <= '0;
      note_q  <= '0;
      valid_q <= 1'b0;
      rd1_q   <= 1'b0;
      rd2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rp_q    <= rp_d;
      len_q   <= len_d;
      full_q  <= full_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      wdata_q <= wdata_d;
      note_q  <= note_d;
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
    end
  end
  assign ram_addr   = addr_q;
  assign ram_wren   = wren_q;
  assign ram_wdata  = wdata_q;
  assign note_out   = note_q;
  assign note_valid = valid_q;
  assign rec_len    = len_q;
  assign full       = full_q;
  assign state      = state_q;
endmodule

// File: doc/note_seq_ctrl.md
Name: note_seq_ctrl

Overview:
- Sequencer for the 64x32 note RAM in the recording datapath. It owns the RAM address, write enable and write data in both record and playback modes.
- Record: writes one captured note per beat tick at an incrementing address and tracks the recorded length.
- Playback: reads the recorded notes back one per tick, optionally loops, and presents each note with a one-cycle valid pulse for the audio/HEX stage.

Parameters:
- ADDR_W, 6, RAM address width.
- DATA_W, 32, note word width (30 fret/string bits plus 2 spare bits).
- DEPTH, 64, RAM depth (equal to 2**ADDR_W).

Ports:
- clk  in  1  system clock (CLOCK_50).
- resetn  in  1  asynchronous reset, active-low.
- tick  in  1  beat pulse from the clock divider, one clk wide.
- rec_start  in  1  one-cycle command: begin recording.
- play_start  in  1  one-cycle command: begin playback.
- stop  in  1  one-cycle command: end the current record or play.
- loop_en  in  1  playback wraps to address 0 after the last note.
- note_in  in  DATA_W  encoded note for the current beat.
- ram_q  in  DATA_W  RAM read data; one-cycle registered-address latency.
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_wren  out  1  RAM write enable (registered).
- ram_wdata  out  DATA_W  RAM write data (registered).
- note_out  out  DATA_W  last note played (registered, held between notes).
- note_valid  out  1  one-cycle pulse when note_out updates.
- rec_len  out  ADDR_W+1  number of notes recorded, 0..DEPTH.
- full  out  1  recording stopped because the RAM filled.
- state  out  2  0=IDLE, 1=REC, 2=PLAY, 3=DRAIN.

Behaviour:
- Async reset: state=IDLE. ram_addr, ram_wren, ram_wdata, note_out, note_valid, rec_len and full all 0. Internal write and read pointers 0. A reset during any operation aborts it and clears rec_len.
- IDLE:
  - rec_start -> REC; pointer, rec_len and full cleared.
  - play_start with rec_len>0 -> PLAY; read pointer set to 0.
  - play_start with rec_len==0 is ignored.
  - rec_start and play_start in the same cycle: REC wins.
  - stop and tick have no effect.
  - ram_addr=0, ram_wren=0.
- REC:
  - tick in cycle t -> in cycle t+1: ram_wren=1 (exactly one cycle), ram_addr=wp, ram_wdata=note_in sampled at t.
  - At the end of cycle t+1: wp and rec_len increment.
  - When rec_len reaches DEPTH: full=1, next state IDLE, and no further writes occur.
  - stop with no tick -> IDLE next cycle.
  - stop together with tick -> that write completes, then IDLE.
  - play_start is ignored in REC.
- PLAY:
  - tick in cycle t -> ram_addr=rp in t+1, ram_q valid in t+2, note_out=ram_q and note_valid=1 in t+3. Tick-to-valid latency is 3 cycles.
  - rp increments with each issued read.
  - Read issued at rp==rec_len-1 with loop_en=1 (sampled at that tick): rp wraps to 0 and play continues.
  - Same condition with loop_en=0: state goes to DRAIN.
  - Ticks during an outstanding read never occur at the divider rates; if one does, it is ignored.
- DRAIN:
  - Ticks are ignored.
  - The outstanding note_valid is emitted, then the state returns to IDLE in the cycle after note_valid.
- stop in PLAY or DRAIN:
  - Next state is IDLE.
  - Any outstanding read is discarded: no note_valid.
  - note_out holds its last value.
- rec_start in PLAY or DRAIN is ignored.
- ram_wren is never 1 outside REC.
- rec_len and full are retained across IDLE and PLAY until the next rec_start or reset.

Test Plan:
1. Reset; rec_start; 3 ticks with note_in=0x00000001, 0x00000040, 0x00020000; stop -> single-cycle writes at addr 0,1,2 with that data; rec_len=3; state=0.
2. After test 1, loop_en=0, play_start, 3 ticks -> note_valid 3 cycles after each tick with note_out=0x1, 0x40, 0x20000. state=3 after the third tick, then 0 the cycle after the last valid.
3. After test 1, loop_en=1, play_start, 5 ticks -> note_out sequence 0x1, 0x40, 0x20000, 0x1, 0x40; state stays 2.
4. rec_start; 64 ticks with note_in=tick index -> full=1, rec_len=64, state=0; a 65th tick produces no ram_wren.
5. From reset, play_start -> state stays 0. Simultaneous rec_start and play_start -> state=1.
6. stop one cycle after a play tick -> no note_valid, state=0. Async resetn low mid-REC -> all outputs 0 immediately, with no clock edge needed.
